// File: rtl/pll_reconfig_if.sv
// Request/status and PLL-facing signals of pll_reconfig_ctrl.
// master = requester/PLL model side, slave = controller side.
interface pll_reconfig_if #(
   parameter int SEL_W = 2
);
   logic             req;
   logic [SEL_W-1:0] sel;
   logic             ready;
   logic             cfg_err;
   logic             pll_lock;
   logic             pll_reset;
   logic [5:0]       idsel;
   logic [5:0]       fbdsel;
   logic [5:0]       odsel;
   logic             locked;
   logic             fail;

   modport master (
      output req, sel, pll_lock,
      input  ready, cfg_err, pll_reset, idsel, fbdsel, odsel, locked, fail
   );

   modport slave (
      input  req, sel, pll_lock,
      output ready, cfg_err, pll_reset, idsel, fbdsel, odsel, locked, fail
   );
endinterface

// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration controller: applies a divider preset, pulses PLL reset and waits for stable lock with retries.
// Optional macro PLL_RELOCK_EN: lock loss while locked restarts the lock sequence instead of failing.
module pll_reconfig_ctrl #(
   parameter int                         NUM_PRESETS   = 4,
   parameter logic [6*NUM_PRESETS-1:0]   PRESET_IDIV   = '0,
   parameter logic [6*NUM_PRESETS-1:0]   PRESET_FBDIV  = '0,
   parameter logic [6*NUM_PRESETS-1:0]   PRESET_ODIV   = '0,
   parameter int                         RESET_CYCLES  = 16,
   parameter int                         LOCK_TIMEOUT  = 4096,
   parameter int                         STABLE_CYCLES = 256,
   parameter int                         MAX_RETRIES   = 3
) (
   input  logic          clkin,
   input  logic          reset,
   pll_reconfig_if.slave bus
);
   localparam int SEL_W = (NUM_PRESETS > 1) ? $clog2(NUM_PRESETS) : 1;
   localparam int TMAX  = (LOCK_TIMEOUT > STABLE_CYCLES)
                        ? ((LOCK_TIMEOUT > RESET_CYCLES) ? LOCK_TIMEOUT : RESET_CYCLES)
                        : ((STABLE_CYCLES > RESET_CYCLES) ? STABLE_CYCLES : RESET_CYCLES);
   localparam int TW    = $clog2(TMAX + 1);
   localparam int RW    = $clog2(MAX_RETRIES + 1);

   typedef enum logic [2:0] {
      ST_RST    = 3'd0,
      ST_WAIT   = 3'd1,
      ST_STABLE = 3'd2,
      ST_LOCKED = 3'd3,
      ST_FAIL   = 3'd4
   } state_t;

   function automatic logic [5:0] preset_field(input logic [6*NUM_PRESETS-1:0] vec,
                                               input logic [SEL_W-1:0]         idx);
      return vec[6*idx +: 6];
   endfunction

   state_t           state_r, state_nxt_s, retry_state_s;
   logic [TW-1:0]    timer_r, timer_nxt_s;
   logic [RW-1:0]    retry_r, retry_nxt_s, retry_inc_s;
   logic             sync1_r, sync2_r, lock_s;
   logic [SEL_W-1:0] sel_s;
   logic             sel_ok_s, req_ok_s, req_bad_s;
   logic [5:0]       preset_id_s, preset_fb_s, preset_od_s;
   logic [5:0]       idsel_r, fbdsel_r, odsel_r;
   logic [5:0]       idsel_nxt_s, fbdsel_nxt_s, odsel_nxt_s;
   logic             cfg_err_r, cfg_err_nxt_s;
   logic             ready_r, pll_reset_r, locked_r, fail_r;

   assign lock_s        = sync2_r;
   assign sel_s         = bus.sel;
   assign sel_ok_s      = (32'(sel_s) < 32'(NUM_PRESETS));
   assign req_ok_s      = bus.req && ready_r && sel_ok_s;
   assign req_bad_s     = bus.req && ready_r && !sel_ok_s;
   assign preset_id_s   = preset_field(PRESET_IDIV, sel_s);
   assign preset_fb_s   = preset_field(PRESET_FBDIV, sel_s);
   assign preset_od_s   = preset_field(PRESET_ODIV, sel_s);
   assign retry_inc_s   = retry_r + RW'(1);
   assign retry_state_s = (retry_inc_s < RW'(MAX_RETRIES)) ? ST_RST : ST_FAIL;

   // Two-flop synchronizer for the asynchronous PLL lock indication.
   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= bus.pll_lock;
         sync2_r <= sync1_r;
      end
   end

   // Next-state, counter and divider-select logic.
   always_comb begin
      state_nxt_s   = state_r;
      timer_nxt_s   = timer_r;
      retry_nxt_s   = retry_r;
      idsel_nxt_s   = idsel_r;
      fbdsel_nxt_s  = fbdsel_r;
      odsel_nxt_s   = odsel_r;
      cfg_err_nxt_s = 1'b0;
      case (state_r)
         ST_RST: begin
            if (timer_r == TW'(RESET_CYCLES - 1)) begin
               state_nxt_s = ST_WAIT;
               timer_nxt_s = '0;
            end else begin
               timer_nxt_s = timer_r + TW'(1);
            end
         end
         ST_WAIT: begin
            // The cycle that first sees lock counts toward the stable run.
            if (lock_s) begin
               if (STABLE_CYCLES == 1) begin
                  state_nxt_s = ST_LOCKED;
                  timer_nxt_s = '0;
               end else begin
                  state_nxt_s = ST_STABLE;
                  timer_nxt_s = TW'(1);
               end
            end else if (timer_r == TW'(LOCK_TIMEOUT - 1)) begin
               state_nxt_s = retry_state_s;
               retry_nxt_s = retry_inc_s;
               timer_nxt_s = '0;
            end else begin
               timer_nxt_s = timer_r + TW'(1);
            end
         end
         ST_STABLE: begin
            if (!lock_s) begin
               state_nxt_s = retry_state_s;
               retry_nxt_s = retry_inc_s;
               timer_nxt_s = '0;
            end else if (timer_r == TW'(STABLE_CYCLES - 1)) begin
               state_nxt_s = ST_LOCKED;
               timer_nxt_s = '0;
            end else begin
               timer_nxt_s = timer_r + TW'(1);
            end
         end
         ST_LOCKED: begin
            if (req_ok_s) begin
               state_nxt_s  = ST_RST;
               timer_nxt_s  = '0;
               retry_nxt_s  = '0;
               idsel_nxt_s  = preset_id_s;
               fbdsel_nxt_s = preset_fb_s;
               odsel_nxt_s  = preset_od_s;
            end else begin
               cfg_err_nxt_s = req_bad_s;
               if (!lock_s) begin
`ifdef PLL_RELOCK_EN
                  state_nxt_s = ST_RST;
                  timer_nxt_s = '0;
                  retry_nxt_s = '0;
`else
                  state_nxt_s = ST_FAIL;
`endif
               end else begin
                  state_nxt_s = ST_LOCKED;
               end
            end
         end
         ST_FAIL: begin
            if (req_ok_s) begin
               state_nxt_s  = ST_RST;
               timer_nxt_s  = '0;
               retry_nxt_s  = '0;
               idsel_nxt_s  = preset_id_s;
               fbdsel_nxt_s = preset_fb_s;
               odsel_nxt_s  = preset_od_s;
            end else begin
               cfg_err_nxt_s = req_bad_s;
            end
         end
         default: begin
            state_nxt_s = ST_RST;
            timer_nxt_s = '0;
         end
      endcase
   end

   // State, counters and registered outputs; outputs are decoded from the next state.
   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         state_r     <= ST_RST;
         timer_r     <= '0;
         retry_r     <= '0;
         idsel_r     <= PRESET_IDIV[5:0];
         fbdsel_r    <= PRESET_FBDIV[5:0];
         odsel_r     <= PRESET_ODIV[5:0];
         cfg_err_r   <= 1'b0;
         ready_r     <= 1'b0;
         pll_reset_r <= 1'b1;
         locked_r    <= 1'b0;
         fail_r      <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         timer_r     <= timer_nxt_s;
         retry_r     <= retry_nxt_s;
         idsel_r     <= idsel_nxt_s;
         fbdsel_r    <= fbdsel_nxt_s;
         odsel_r     <= odsel_nxt_s;
         cfg_err_r   <= cfg_err_nxt_s;
         ready_r     <= (state_nxt_s == ST_LOCKED) || (state_nxt_s == ST_FAIL);
         pll_reset_r <= (state_nxt_s == ST_RST);
         locked_r    <= (state_nxt_s == ST_LOCKED);
         fail_r      <= (state_nxt_s == ST_FAIL);
      end
   end

   assign bus.ready     = ready_r;
   assign bus.cfg_err   = cfg_err_r;
   assign bus.pll_reset = pll_reset_r;
   assign bus.idsel     = idsel_r;
   assign bus.fbdsel    = fbdsel_r;
   assign bus.odsel     = odsel_r;
   assign bus.locked    = locked_r;
   assign bus.fail      = fail_r;
endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Directed bench for pll_reconfig_ctrl with three presets and default timing parameters.
module tb_pll_reconfig_ctrl;
   localparam int          NP    = 3;
   localparam logic [17:0] IDIV  = {6'd3, 6'd2, 6'd1};
   localparam logic [17:0] FBDIV = {6'd13, 6'd12, 6'd11};
   localparam logic [17:0] ODIV  = {6'd23, 6'd22, 6'd21};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_errors = 0;
   int   n;

   pll_reconfig_if #(.SEL_W(2)) bus ();

   pll_reconfig_ctrl #(
      .NUM_PRESETS  (NP),
      .PRESET_IDIV  (IDIV),
      .PRESET_FBDIV (FBDIV),
      .PRESET_ODIV  (ODIV),
      .RESET_CYCLES (16),
      .LOCK_TIMEOUT (4096),
      .STABLE_CYCLES(256),
      .MAX_RETRIES  (3)
   ) dut (
      .clkin(clk),
      .reset(rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int cnt);
      for (int i = 0; i < cnt; i++) tick();
   endtask

   // Ticks until pll_reset equals lvl; cnt saturates at maxn if it never does.
   task automatic wait_pll_reset(input logic lvl, input int maxn, output int cnt);
      cnt = 0;
      while (bus.pll_reset !== lvl && cnt < maxn) begin
         tick();
         cnt++;
      end
   endtask

   task automatic req_pulse(input logic [1:0] s);
      bus.sel = s;
      bus.req = 1'b1;
      tick();
      bus.req = 1'b0;
   endtask

   task automatic relock_check(input string tag);
      int c;
      wait_pll_reset(1'b0, 40, c);
      chk({tag, "_rst_len"}, c, 32'd16);
      tick_n(255);
      chk({tag, "_early"}, bus.locked, 32'd0);
      tick();
      chk({tag, "_locked"}, bus.locked, 32'd1);
   endtask

   initial begin
      bus.req      = 1'b0;
      bus.sel      = 2'd0;
      bus.pll_lock = 1'b0;
      tick_n(3);
      chk("rst_pll_reset", bus.pll_reset, 32'd1);
      chk("rst_locked", bus.locked, 32'd0);
      chk("rst_fail", bus.fail, 32'd0);
      chk("rst_ready", bus.ready, 32'd0);
      chk("rst_cfg_err", bus.cfg_err, 32'd0);
      chk("rst_idsel", bus.idsel, 32'd1);
      chk("rst_fbdsel", bus.fbdsel, 32'd11);
      chk("rst_odsel", bus.odsel, 32'd21);
      rst = 1'b0;

      // Initial lock: 16-cycle reset, lock 10 cycles later, 256+2 cycles to locked.
      wait_pll_reset(1'b0, 40, n);
      chk("init_rst_len", n, 32'd16);
      tick_n(4);
      req_pulse(2'd2);
      chk("busy_req_idsel", bus.idsel, 32'd1);
      chk("busy_req_pll_reset", bus.pll_reset, 32'd0);
      req_pulse(2'd3);
      chk("busy_req_cfg_err", bus.cfg_err, 32'd0);
      tick_n(4);
      bus.pll_lock = 1'b1;
      tick_n(257);
      chk("init_early", bus.locked, 32'd0);
      tick();
      chk("init_locked", bus.locked, 32'd1);
      chk("init_ready", bus.ready, 32'd1);

      // Reconfigure to preset 2.
      req_pulse(2'd2);
      chk("sel2_idsel", bus.idsel, 32'd3);
      chk("sel2_fbdsel", bus.fbdsel, 32'd13);
      chk("sel2_odsel", bus.odsel, 32'd23);
      chk("sel2_pll_reset", bus.pll_reset, 32'd1);
      chk("sel2_locked", bus.locked, 32'd0);
      chk("sel2_ready", bus.ready, 32'd0);
      relock_check("sel2");

      // Out-of-range preset.
      req_pulse(2'd3);
      chk("bad_cfg_err", bus.cfg_err, 32'd1);
      chk("bad_locked", bus.locked, 32'd1);
      chk("bad_idsel", bus.idsel, 32'd3);
      chk("bad_pll_reset", bus.pll_reset, 32'd0);
      tick();
      chk("bad_cfg_err_end", bus.cfg_err, 32'd0);
      chk("bad_locked_hold", bus.locked, 32'd1);

      // One-cycle lock glitch during STABLE.
      req_pulse(2'd0);
      chk("sel0_idsel", bus.idsel, 32'd1);
      wait_pll_reset(1'b0, 40, n);
      chk("sel0_rst_len", n, 32'd16);
      tick_n(10);
      bus.pll_lock = 1'b0;
      tick();
      bus.pll_lock = 1'b1;
      tick();
      chk("stab_glitch_pre", bus.pll_reset, 32'd0);
      tick();
      chk("stab_glitch_rst", bus.pll_reset, 32'd1);
      chk("stab_glitch_idsel", bus.idsel, 32'd1);
      relock_check("stab_glitch");

      // One-cycle lock glitch while LOCKED.
      bus.pll_lock = 1'b0;
      tick();
      bus.pll_lock = 1'b1;
      tick();
      chk("lk_glitch_pre", bus.locked, 32'd1);
      tick();
      chk("lk_glitch_locked", bus.locked, 32'd0);
`ifdef PLL_RELOCK_EN
      chk("lk_glitch_rst", bus.pll_reset, 32'd1);
      chk("lk_glitch_fail", bus.fail, 32'd0);
      relock_check("lk_relock");
`else
      chk("lk_glitch_fail", bus.fail, 32'd1);
      chk("lk_glitch_ready", bus.ready, 32'd1);
      chk("lk_glitch_rst", bus.pll_reset, 32'd0);
`endif

      // Preset 1 with no lock: three attempts time out, then FAIL.
      bus.pll_lock = 1'b0;
      req_pulse(2'd1);
      chk("to_fail_clear", bus.fail, 32'd0);
      chk("to_pll_reset", bus.pll_reset, 32'd1);
      chk("to_idsel", bus.idsel, 32'd2);
      for (int a = 0; a < 3; a++) begin
         wait_pll_reset(1'b0, 40, n);
         chk("to_rst_len", n, 32'd16);
         if (a < 2) begin
            wait_pll_reset(1'b1, 4200, n);
            chk("to_wait_len", n, 32'd4096);
            chk("to_retry_idsel", bus.idsel, 32'd2);
         end else begin
            tick_n(4095);
            chk("to_fail_early", bus.fail, 32'd0);
            tick();
            chk("to_fail", bus.fail, 32'd1);
            chk("to_ready", bus.ready, 32'd1);
            chk("to_fail_pll_reset", bus.pll_reset, 32'd0);
            chk("to_fail_idsel", bus.idsel, 32'd2);
            chk("to_fail_fbdsel", bus.fbdsel, 32'd12);
         end
      end

      // Asynchronous reset in the middle of WAIT.
      req_pulse(2'd2);
      chk("fail_req_fail", bus.fail, 32'd0);
      chk("fail_req_idsel", bus.idsel, 32'd3);
      wait_pll_reset(1'b0, 40, n);
      chk("mid_rst_len", n, 32'd16);
      tick_n(100);
      #3;
      rst = 1'b1;
      #1;
      chk("async_pll_reset", bus.pll_reset, 32'd1);
      chk("async_idsel", bus.idsel, 32'd1);
      chk("async_fbdsel", bus.fbdsel, 32'd11);
      chk("async_odsel", bus.odsel, 32'd21);
      chk("async_locked", bus.locked, 32'd0);
      chk("async_fail", bus.fail, 32'd0);
      chk("async_ready", bus.ready, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_pll_reset(1'b0, 40, n);
      chk("post_rst_len", n, 32'd16);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/pll_reconfig_ctrl.md
PLL_RECONFIG_CTRL -- requirements
Module: pll_reconfig_ctrl

Interface
REQ-001 Parameter NUM_PRESETS, default 4: number of divider presets (1..16).
REQ-002 Parameter PRESET_IDIV / PRESET_FBDIV / PRESET_ODIV, default all-zero vectors of 6*NUM_PRESETS bits: per-preset divider selects, preset k in bits [6k+5:6k].
REQ-003 Parameter RESET_CYCLES, default 16: PLL reset pulse length in clkin cycles (>=1).
REQ-004 Parameter LOCK_TIMEOUT, default 4096: max cycles waiting for lock after reset release.
REQ-005 Parameter STABLE_CYCLES, default 256: consecutive locked cycles required before declaring lock.
REQ-006 Parameter MAX_RETRIES, default 3: reset attempts per request before failure (>=1).
REQ-007 clkin  in  1  sole clock; reset is asynchronous and active-high.
REQ-008 reset  in  1  asynchronous active-high reset.
REQ-009 req  in  1  single-cycle reconfiguration request, sampled only while ready=1.
REQ-010 sel  in  clog2(NUM_PRESETS) (min 1)  preset index, sampled with req.
REQ-011 ready  out  1  high in LOCKED or FAIL.
REQ-012 cfg_err  out  1  one-cycle pulse: req with sel>=NUM_PRESETS rejected.
REQ-013 pll_lock  in  1  raw PLL lock, asynchronous to clkin.
REQ-014 pll_reset  out  1  PLL reset, active-high.
REQ-015 idsel / fbdsel / odsel  out  6 each  registered divider selects to PLL.
REQ-016 locked  out  1  PLL declared stably locked.
REQ-017 fail  out  1  retries exhausted.

Function
REQ-018 pll_lock SHALL pass a 2-flop synchronizer; all FSM decisions use synchronized lock (2-cycle latency).
REQ-019 FSM states: RST, WAIT, STABLE, LOCKED, FAIL.
REQ-020 RST: pll_reset=1 for exactly RESET_CYCLES cycles, then WAIT with timer cleared.
REQ-021 WAIT: pll_reset=0; synced lock=1 -> STABLE; timer reaching LOCK_TIMEOUT -> retry decision.
REQ-022 STABLE: lock held STABLE_CYCLES consecutive cycles -> LOCKED; lock drop -> retry decision.
REQ-023 Retry decision: increment retry count; count<MAX_RETRIES -> RST, else FAIL.
REQ-024 LOCKED: locked=1; valid req -> RST next cycle, locked=0 next cycle; lock loss per REQ-033/034.
REQ-025 FAIL: fail=1, pll_reset=0; valid req -> RST, fail=0 next cycle.
REQ-026 Accepted req in cycle N: divider outputs take preset sel and pll_reset=1 at N+1; retry count cleared.
REQ-027 Divider outputs SHALL change only on accepted req or reset, never during retries.
REQ-028 req with sel>=NUM_PRESETS: ignored, state and dividers unchanged, cfg_err=1 at N+1.
REQ-029 req while ready=0 SHALL be ignored without cfg_err.
REQ-030 Lock drop and timer terminal count in same cycle: treated as single retry event.

Reset
REQ-031 reset SHALL force state RST with counters cleared, dividers=preset 0, pll_reset=1, locked=0, fail=0, cfg_err=0, synchronizer=0.
REQ-032 After reset release, sequencing proceeds as for an accepted req of preset 0; reset mid-sequence aborts immediately.

Configuration
REQ-033 With PLL_RELOCK_EN defined: lock loss in LOCKED -> RST with retry count cleared, same preset, locked=0 next cycle.
REQ-034 Without PLL_RELOCK_EN: lock loss in LOCKED -> FAIL, locked=0 and fail=1 next cycle.

Verification
REQ-035 Reset release, pll_lock rises 10 cycles after pll_reset falls and stays -> pll_reset high 16 cycles, locked=1 after 256+2 stable cycles, ready=1.
REQ-036 LOCKED, req sel=2 -> next cycle dividers = preset 2, pll_reset=1, locked=0; relock reaches LOCKED.
REQ-037 pll_lock held 0 -> three timeouts of 4096 cycles, three RST pulses, then fail=1, ready=1, dividers unchanged.
REQ-038 NUM_PRESETS=3, req sel=3 in LOCKED -> cfg_err one-cycle pulse, locked stays 1, dividers unchanged.
REQ-039 Lock glitch low 1 cycle during STABLE -> retry count 1, new RST pulse; glitch in LOCKED -> RST (PLL_RELOCK_EN) or fail=1 (not defined).
REQ-040 reset asserted mid-WAIT -> outputs at reset values same cycle (asynchronous), dividers=preset 0.
